// File: rtl/ringosc_freq_meter_pkg.sv
// Shared definitions for the ring oscillator frequency meter.
package ringosc_freq_meter_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Default widths
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_GATE_W        = 16;
    localparam int DEF_SETTLE_CYCLES = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ringosc_freq_meter_sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge pulse generator.
module ringosc_freq_meter_sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchronizer chain plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync_o = s2_q;
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/ringosc_freq_meter.sv
// Ring oscillator frequency meter: enable, settle, count edges over a gate window.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; result registers hold last measurement
// SETTLE  | oscillator enabled, timer runs 0..SETTLE_CYCLES, no counting
// MEASURE | gate_q cycles of rising-edge counting (saturating)
// DONE    | one cycle, done pulse, oscillator disabled
module ringosc_freq_meter
    import ringosc_freq_meter_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int GATE_W        = DEF_GATE_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [GATE_W-1:0] gate_cycles_i,
    input  logic              osc_in_i,
    output logic              osc_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o
);

    localparam int TMR_W = max_int(GATE_W, $clog2(SETTLE_CYCLES + 1));
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              osc_en_q, busy_q, done_q;
    logic [TMR_W-1:0]  gate_last;
    logic              osc_sync;
    logic              osc_rise;

    ringosc_freq_meter_sync_edge_det u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (osc_in_i),
        .sync_o  (osc_sync),
        .rise_o  (osc_rise)
    );

    // MEASURE only runs with gate_q != 0, so the subtraction cannot wrap there
    assign gate_last = TMR_W'(gate_q) - TMR_ONE;

    // Next-state, timer and saturating counter logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        gate_d  = gate_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SETTLE;
                    gate_d  = gate_cycles_i;
                    timer_d = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    state_d = (gate_q == '0) ? ST_DONE : ST_MEASURE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ST_MEASURE: begin
                if (osc_rise) begin
                    if (&count_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                if (timer_q == gate_last) begin
                    timer_d = '0;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs decoded from next state so they are glitch-free flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            gate_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            osc_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            gate_q   <= gate_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            osc_en_q <= (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign osc_en_o   = osc_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    // Synchronized level is available for observation but not needed here
    logic unused_sync;
    assign unused_sync = osc_sync;

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Directed testbench for ringosc_freq_meter (CNT_W=4, SETTLE_CYCLES=16).
module tb_ringosc_freq_meter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] gate_cycles;
    logic        osc_in;
    logic        osc_en;
    logic        busy;
    logic        done;
    logic [3:0]  count;
    logic        overflow;

    int n_vec;
    int n_err;
    int osc_half;
    int osc_ph;
    logic osc_level;

    ringosc_freq_meter #(
        .CNT_W         (4),
        .GATE_W        (16),
        .SETTLE_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .gate_cycles_i (gate_cycles),
        .osc_in_i      (osc_in),
        .osc_en_o      (osc_en),
        .busy_o        (busy),
        .done_o        (done),
        .count_o       (count),
        .overflow_o    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator model: toggles every osc_half clocks, or holds osc_level when osc_half==0
    initial begin
        osc_in = 1'b0;
        osc_ph = 0;
        forever begin
            @(negedge clk);
            if (osc_half == 0) begin
                osc_in = osc_level;
            end else if (osc_ph >= osc_half - 1) begin
                osc_ph = 0;
                osc_in = ~osc_in;
            end else begin
                osc_ph++;
            end
        end
    end

    // Pulse start, optionally re-pulse at offsets s1..s3, and observe for a fixed number of cycles.
    // Offset i is the cycle following edge k+i, where k is the edge that accepts start.
    task automatic run(input int gate, input int new_gate, input int cycles,
                       input int s1, input int s2, input int s3,
                       output int done_at, output int n_done, output int en_cnt,
                       output int busy_cnt, output logic en0);
        done_at  = -1;
        n_done   = 0;
        en_cnt   = 0;
        busy_cnt = 0;
        en0      = 1'b0;
        @(negedge clk);
        gate_cycles = gate[15:0];
        start = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (i == 0) begin
                gate_cycles = new_gate[15:0];
                en0 = osc_en;
            end
            start = (i == s1) || (i == s2) || (i == s3);
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = i;
            end
            if (osc_en) en_cnt++;
            if (busy) busy_cnt++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({osc_en, busy, done, overflow} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 0000", {osc_en, busy, done, overflow});
        end
        n_vec++;
        if (count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_period8();
        int d_at, n_d, en_c, b_c;
        logic e0;
        osc_half = 4;
        run(64, 64, 100, -1, -1, -1, d_at, n_d, en_c, b_c, e0);
        n_vec++;
        if (e0 !== 1'b1) begin
            n_err++; $display("FAIL p8_osc_en_rise: got %b expected 1", e0);
        end
        n_vec++;
        if (d_at != 81) begin
            n_err++; $display("FAIL p8_done_latency: got %0d expected 81", d_at);
        end
        n_vec++;
        if (n_d != 1) begin
            n_err++; $display("FAIL p8_done_pulses: got %0d expected 1", n_d);
        end
        n_vec++;
        if (count !== 4'd8) begin
            n_err++; $display("FAIL p8_count: got %0d expected 8", count);
        end
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL p8_overflow: got %b expected 0", overflow);
        end
        n_vec++;
        if (b_c != 82) begin
            n_err++; $display("FAIL p8_busy_cycles: got %0d expected 82", b_c);
        end
        n_vec++;
        if (en_c != 81) begin
            n_err++; $display("FAIL p8_osc_en_cycles: got %0d expected 81", en_c);
        end
    endtask

    task automatic test_saturation();
        int d_at, n_d, en_c, b_c;
        logic e0;
        osc_half = 1;
        run(64, 64, 100, -1, -1, -1, d_at, n_d, en_c, b_c, e0);
        n_vec++;
        if (count !== 4'd15) begin
            n_err++; $display("FAIL sat_count: got %0d expected 15", count);
        end
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++; $display("FAIL sat_overflow: got %b expected 1", overflow);
        end
        run(8, 8, 40, -1, -1, -1, d_at, n_d, en_c, b_c, e0);
        n_vec++;
        if (d_at != 25) begin
            n_err++; $display("FAIL g8_done_latency: got %0d expected 25", d_at);
        end
        n_vec++;
        if (count !== 4'd4) begin
            n_err++; $display("FAIL g8_count: got %0d expected 4", count);
        end
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL g8_overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_gate_zero();
        int d_at, n_d, en_c, b_c;
        logic e0;
        osc_half = 1;
        run(0, 0, 40, -1, -1, -1, d_at, n_d, en_c, b_c, e0);
        n_vec++;
        if (d_at != 17) begin
            n_err++; $display("FAIL g0_done_latency: got %0d expected 17", d_at);
        end
        n_vec++;
        if (en_c != 17) begin
            n_err++; $display("FAIL g0_osc_en_cycles: got %0d expected 17", en_c);
        end
        n_vec++;
        if (count !== 4'd0) begin
            n_err++; $display("FAIL g0_count: got %0d expected 0", count);
        end
        n_vec++;
        if (n_d != 1) begin
            n_err++; $display("FAIL g0_done_pulses: got %0d expected 1", n_d);
        end
    endtask

    task automatic test_ignored_start();
        int d_at, n_d, en_c, b_c;
        logic e0;
        osc_half = 4;
        run(64, 8, 130, 5, 40, 81, d_at, n_d, en_c, b_c, e0);
        n_vec++;
        if (d_at != 81) begin
            n_err++; $display("FAIL ign_done_latency: got %0d expected 81", d_at);
        end
        n_vec++;
        if (n_d != 1) begin
            n_err++; $display("FAIL ign_done_pulses: got %0d expected 1", n_d);
        end
        n_vec++;
        if (count !== 4'd8) begin
            n_err++; $display("FAIL ign_count: got %0d expected 8", count);
        end
        n_vec++;
        if (b_c != 82) begin
            n_err++; $display("FAIL ign_busy_cycles: got %0d expected 82", b_c);
        end
    endtask

    task automatic test_mid_reset();
        int n_d;
        osc_half = 4;
        @(negedge clk);
        gate_cycles = 16'd64;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        n_vec++;
        if (count === 4'd0) begin
            n_err++; $display("FAIL mr_pre_count: got %0d expected nonzero", count);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({osc_en, busy, overflow} !== 3'b000) begin
            n_err++; $display("FAIL mr_flags: got %b expected 000", {osc_en, busy, overflow});
        end
        n_vec++;
        if (count !== 4'd0) begin
            n_err++; $display("FAIL mr_count: got %0d expected 0", count);
        end
        n_d = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || busy) n_d++;
        end
        n_vec++;
        if (n_d != 0) begin
            n_err++; $display("FAIL mr_no_done: got %0d active cycles expected 0", n_d);
        end
    endtask

    task automatic test_dead_ring();
        int d_at, n_d, en_c, b_c;
        logic e0;
        osc_half  = 0;
        osc_level = 1'b1;
        run(100, 100, 130, -1, -1, -1, d_at, n_d, en_c, b_c, e0);
        n_vec++;
        if (d_at != 117) begin
            n_err++; $display("FAIL dead1_done_latency: got %0d expected 117", d_at);
        end
        n_vec++;
        if (count !== 4'd0) begin
            n_err++; $display("FAIL dead1_count: got %0d expected 0", count);
        end
        osc_level = 1'b0;
        run(100, 100, 130, -1, -1, -1, d_at, n_d, en_c, b_c, e0);
        n_vec++;
        if (d_at != 117) begin
            n_err++; $display("FAIL dead0_done_latency: got %0d expected 117", d_at);
        end
        n_vec++;
        if (count !== 4'd0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL dead0_result: got %0d/%b expected 0/0", count, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int d_at[3];
        int nd;
        int idle;
        osc_half  = 0;
        osc_level = 1'b0;
        nd   = 0;
        idle = 0;
        @(negedge clk);
        gate_cycles = 16'd100;
        start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                if (nd < 3) d_at[nd] = i;
                nd++;
                if (nd == 3) start = 1'b0;
            end else if (!busy && nd > 0 && nd < 3) begin
                idle++;
            end
        end
        start = 1'b0;
        n_vec++;
        if (nd != 3) begin
            n_err++; $display("FAIL b2b_done_pulses: got %0d expected 3", nd);
        end
        if (nd >= 3) begin
            n_vec++;
            if (d_at[0] != 117 || d_at[1] != 236 || d_at[2] != 355) begin
                n_err++;
                $display("FAIL b2b_done_times: got %0d,%0d,%0d expected 117,236,355",
                         d_at[0], d_at[1], d_at[2]);
            end
        end
        n_vec++;
        if (idle != 2) begin
            n_err++; $display("FAIL b2b_idle_cycles: got %0d expected 2", idle);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_final_busy: got %b expected 0", busy);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        start       = 1'b0;
        gate_cycles = 16'd0;
        osc_half    = 0;
        osc_level   = 1'b0;
        test_reset();
        test_period8();
        test_saturation();
        test_gate_zero();
        test_ignored_start();
        test_mid_reset();
        test_dead_ring();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
